// File: rtl/leaf_out_arbiter_pkg.sv
// leaf_out_arbiter_pkg: BFT packet layout and arbiter defaults shared by the leaf egress arbiter.
// Packet = {vld, leaf, port, addr, payload}, MSB first.
package leaf_out_arbiter_pkg;

    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int DEST_BITS     = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int PACKET_BITS   = 1 + DEST_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    localparam int PAYLOAD_LSB = 0;
    localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
    localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
    localparam int VLD_LSB     = LEAF_LSB + NUM_LEAF_BITS;

    localparam int DEFAULT_INIT_CREDIT = 64;
    localparam int STAT_BITS           = 16;

    typedef struct packed {
        logic                     vld;
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] port;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [PAYLOAD_BITS-1:0]  payload;
    } bft_pkt_t;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// leaf_out_arbiter_if: user streams, BFT egress, credit return and destination config of the leaf arbiter.
// LEAF_ARB_STATS_EN adds the stat_sel/stat_cnt grant-counter read port.
interface leaf_out_arbiter_if
    import leaf_out_arbiter_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 4,
    parameter int CREDIT_BITS   = 8
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
    logic [NUM_OUT_PORTS-1:0]              vld_user;
    logic [NUM_OUT_PORTS-1:0]              ack_user;
    logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;
    logic                                  resend;
    logic                                  credit_vld;
    logic [NUM_PORT_BITS-1:0]              credit_port;
    logic [CREDIT_BITS-1:0]                credit_amt;
    logic                                  cfg_wr;
    logic [NUM_PORT_BITS-1:0]              cfg_port;
    logic [DEST_BITS-1:0]                  cfg_dest;
    logic                                  credit_err;
`ifdef LEAF_ARB_STATS_EN
    logic [NUM_PORT_BITS-1:0]              stat_sel;
    logic [STAT_BITS-1:0]                  stat_cnt;

    modport slave (
        input  din_user, vld_user, resend, credit_vld, credit_port, credit_amt,
               cfg_wr, cfg_port, cfg_dest, stat_sel,
        output ack_user, dout_leaf_interface2bft, credit_err, stat_cnt
    );
    modport master (
        output din_user, vld_user, resend, credit_vld, credit_port, credit_amt,
               cfg_wr, cfg_port, cfg_dest, stat_sel,
        input  ack_user, dout_leaf_interface2bft, credit_err, stat_cnt
    );
`else
    modport slave (
        input  din_user, vld_user, resend, credit_vld, credit_port, credit_amt,
               cfg_wr, cfg_port, cfg_dest,
        output ack_user, dout_leaf_interface2bft, credit_err
    );
    modport master (
        output din_user, vld_user, resend, credit_vld, credit_port, credit_amt,
               cfg_wr, cfg_port, cfg_dest,
        input  ack_user, dout_leaf_interface2bft, credit_err
    );
`endif

endinterface

// File: rtl/leaf_rr_picker.sv
// leaf_rr_picker: combinational round-robin picker; selects the first request at or after i_ptr,
// wrapping modulo N.
module leaf_rr_picker #(
    parameter int N        = 4,
    parameter int IDX_BITS = 4
) (
    input  logic [N-1:0]        i_req,
    input  logic [IDX_BITS-1:0] i_ptr,
    output logic [N-1:0]        o_gnt,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_any
);
    int w_best;
    int w_dist;

    always_comb begin
        w_best = N;
        w_dist = 0;
        o_idx  = '0;
        for (int i = 0; i < N; i++) begin
            // distance walking upward from the pointer, wrapping past N-1
            w_dist = (i >= int'(i_ptr)) ? i - int'(i_ptr) : i + N - int'(i_ptr);
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IDX_BITS'(i);
            end
        end
    end

    assign o_any = |i_req;

    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_any && (o_idx == IDX_BITS'(i));
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: credit-based round-robin arbiter merging NUM_OUT_PORTS user streams onto one BFT link.
// Optional LEAF_ARB_STATS_EN adds saturating per-port grant counters readable through stat_sel/stat_cnt.
module leaf_out_arbiter
    import leaf_out_arbiter_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 4,
    parameter int CREDIT_BITS   = 8,
    parameter int INIT_CREDIT   = DEFAULT_INIT_CREDIT
) (
    input logic               clk_bft,
    input logic               reset_bft_n,
    leaf_out_arbiter_if.slave bus
);
    localparam logic [CREDIT_BITS:0]     CREDIT_MAX = {1'b0, {CREDIT_BITS{1'b1}}};
    localparam logic [NUM_PORT_BITS-1:0] LAST_PORT  = NUM_PORT_BITS'(NUM_OUT_PORTS - 1);

    logic [NUM_OUT_PORTS-1:0]                    r_ack;
    bft_pkt_t                                    r_dout;
    logic [NUM_OUT_PORTS-1:0][CREDIT_BITS-1:0]   r_credit;
    logic [NUM_OUT_PORTS-1:0][NUM_ADDR_BITS-1:0] r_seq;
    logic [NUM_OUT_PORTS-1:0][DEST_BITS-1:0]     r_dest;
    logic [NUM_PORT_BITS-1:0]                    r_ptr;
    logic                                        r_err;

    logic [NUM_OUT_PORTS-1:0]                    w_req;
    logic [NUM_OUT_PORTS-1:0]                    w_gnt;
    logic [NUM_PORT_BITS-1:0]                    w_idx;
    logic                                        w_any;
    logic [NUM_PORT_BITS-1:0]                    w_ptr_nxt;
    logic                                        w_port_bad;
    logic [NUM_OUT_PORTS-1:0][CREDIT_BITS:0]     w_sum;
    logic [NUM_OUT_PORTS-1:0]                    w_credit_ovf;
    logic [NUM_OUT_PORTS-1:0][CREDIT_BITS-1:0]   w_credit_nxt;
    bft_pkt_t                                    w_pkt;

    // A port acked this cycle is masked so it cannot win twice in a row; resend blocks all grants.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            w_req[i] = bus.vld_user[i] && (r_credit[i] != '0) && !r_ack[i] && !bus.resend;
        end
    end

    leaf_rr_picker #(
        .N        (NUM_OUT_PORTS),
        .IDX_BITS (NUM_PORT_BITS)
    ) u_picker (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_ptr_nxt  = (w_idx == LAST_PORT) ? '0 : w_idx + 1'b1;
    assign w_port_bad = bus.credit_vld && (int'(bus.credit_port) >= NUM_OUT_PORTS);

    // Grant and credit return may hit the same port; the wide sum catches overflow before saturating.
    always_comb begin
        w_sum        = '0;
        w_credit_ovf = '0;
        w_credit_nxt = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            w_sum[i] = {1'b0, r_credit[i]} - (CREDIT_BITS + 1)'(w_gnt[i]);
            if (bus.credit_vld && !w_port_bad && (bus.credit_port == NUM_PORT_BITS'(i))) begin
                w_sum[i] = w_sum[i] + {1'b0, bus.credit_amt};
            end
            w_credit_ovf[i] = (w_sum[i] > CREDIT_MAX);
            w_credit_nxt[i] = w_credit_ovf[i] ? CREDIT_MAX[CREDIT_BITS-1:0] : w_sum[i][CREDIT_BITS-1:0];
        end
    end

    always_comb begin
        w_pkt = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (w_gnt[i]) begin
                w_pkt.vld                  = 1'b1;
                {w_pkt.leaf, w_pkt.port}   = r_dest[i];
                w_pkt.addr                 = r_seq[i];
                w_pkt.payload              = bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    always_ff @(posedge clk_bft or negedge reset_bft_n) begin
        if (!reset_bft_n) begin
            r_ack  <= '0;
            r_dout <= '0;
            r_ptr  <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                r_credit[i] <= CREDIT_BITS'(INIT_CREDIT);
                r_seq[i]    <= '0;
                r_dest[i]   <= '0;
            end
        end else begin
            r_credit <= w_credit_nxt;
            if (w_port_bad || (|w_credit_ovf)) begin
                r_err <= 1'b1;
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (bus.cfg_wr && (bus.cfg_port == NUM_PORT_BITS'(i))) begin
                    r_dest[i] <= bus.cfg_dest;
                end
            end
            // While stalled the egress word is replayed untouched.
            if (bus.resend) begin
                r_ack <= '0;
            end else begin
                r_ack  <= w_gnt;
                r_dout <= w_pkt;
                if (w_any) begin
                    r_ptr <= w_ptr_nxt;
                    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                        if (w_gnt[i]) begin
                            r_seq[i] <= r_seq[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.ack_user                = r_ack;
    assign bus.dout_leaf_interface2bft = r_dout;
    assign bus.credit_err              = r_err;

`ifdef LEAF_ARB_STATS_EN
    logic [NUM_OUT_PORTS-1:0][STAT_BITS-1:0] r_stat;

    always_ff @(posedge clk_bft or negedge reset_bft_n) begin
        if (!reset_bft_n) begin
            r_stat <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (w_gnt[i] && (r_stat[i] != {STAT_BITS{1'b1}})) begin
                    r_stat[i] <= r_stat[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.stat_cnt = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (bus.stat_sel == NUM_PORT_BITS'(i)) begin
                bus.stat_cnt = r_stat[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: table-driven arbitration vectors plus scoreboarded multi-cycle sequences
// (credit stall/return, saturation, invalid credit port, async reset, address wrap).
module tb_leaf_out_arbiter;
    import leaf_out_arbiter_pkg::*;

    localparam int NP        = 4;
    localparam int CB        = 8;
    localparam int INIT_CRED = 64;
    localparam int NV        = 17;

    logic clk_bft     = 1'b0;
    logic reset_bft_n = 1'b0;
    always #5 clk_bft = ~clk_bft;

    leaf_out_arbiter_if #(.NUM_OUT_PORTS(NP), .CREDIT_BITS(CB)) bus ();

    leaf_out_arbiter #(
        .NUM_OUT_PORTS (NP),
        .CREDIT_BITS   (CB),
        .INIT_CREDIT   (INIT_CRED)
    ) dut (
        .clk_bft     (clk_bft),
        .reset_bft_n (reset_bft_n),
        .bus         (bus)
    );

    typedef logic [PACKET_BITS-1:0] pkt_t;
    typedef struct {
        logic [NP-1:0] vld;
        logic          rs;
        logic [NP-1:0] ack;
        int            port;   // granted port, -1 idle, -2 held by resend
    } vec_t;

    int                       checks = 0;
    int                       errors = 0;
    pkt_t                     sb[$];
    pkt_t                     last_pkt;
    logic [DEST_BITS-1:0]     dest_m[NP];
    logic [NUM_ADDR_BITS-1:0] seq_m[NP];
    int                       credit_m[NP];
    logic [31:0]              din_m[NP];
    vec_t                     tbl[NV];

    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic pkt_t mk(input int p);
        pkt_t pk;
        pk = {1'b1, dest_m[p], seq_m[p], din_m[p]};
        seq_m[p] = seq_m[p] + 1'b1;
        credit_m[p]--;
        return pk;
    endfunction

    task automatic pop_chk(input string nm);
        pkt_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected packet actual=%0h expected=none", nm, bus.dout_leaf_interface2bft);
        end else begin
            e = sb.pop_front();
            chk(nm, 64'(bus.dout_leaf_interface2bft), 64'(e));
            last_pkt = e;
        end
    endtask

    task automatic drive_din();
        for (int p = 0; p < NP; p++) bus.din_user[p*PAYLOAD_BITS +: PAYLOAD_BITS] = din_m[p];
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            dest_m[p]   = '0;
            seq_m[p]    = '0;
            credit_m[p] = INIT_CRED;
        end
        sb.delete();
    endtask

    // Holds port p's request, optionally returning credit on the first cycle, and scores every packet.
    task automatic run_port(input int p, input int n, input int bound, input bit stop, input int amt);
        int cnt;
        cnt = 0;
        if (amt > 0) begin
            credit_m[p]     = (credit_m[p] + amt > 255) ? 255 : credit_m[p] + amt;
            bus.credit_vld  = 1'b1;
            bus.credit_port = NUM_PORT_BITS'(p);
            bus.credit_amt  = CB'(amt);
        end
        for (int k = 0; k < n; k++) sb.push_back(mk(p));
        bus.vld_user[p] = 1'b1;
        for (int c = 0; c < bound; c++) begin
            tick();
            bus.credit_vld = 1'b0;
            if (bus.dout_leaf_interface2bft[PACKET_BITS-1]) begin
                cnt++;
                pop_chk($sformatf("pkt p%0d n%0d", p, cnt));
                if (stop && cnt == n) bus.vld_user[p] = 1'b0;
            end
        end
        bus.vld_user[p] = 1'b0;
        tick();
        if (bus.dout_leaf_interface2bft[PACKET_BITS-1]) begin
            cnt++;
            pop_chk($sformatf("pkt p%0d late", p));
        end
        chk($sformatf("count p%0d", p), 64'(cnt), 64'(n));
        chk($sformatf("sb drained p%0d", p), 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 4'b0100,  2};
        tbl[1]  = '{4'b1111, 1'b0, 4'b1000,  3};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0001,  0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0010,  1};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0100,  2};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0000, -2};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0000, -2};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0000, -2};
        tbl[8]  = '{4'b1111, 1'b0, 4'b1000,  3};
        tbl[9]  = '{4'b0011, 1'b0, 4'b0001,  0};
        tbl[10] = '{4'b0011, 1'b0, 4'b0010,  1};
        tbl[11] = '{4'b0011, 1'b0, 4'b0001,  0};
        tbl[12] = '{4'b0011, 1'b0, 4'b0010,  1};
        tbl[13] = '{4'b0001, 1'b0, 4'b0001,  0};
        tbl[14] = '{4'b0001, 1'b0, 4'b0000, -1};
        tbl[15] = '{4'b0001, 1'b0, 4'b0001,  0};
        tbl[16] = '{4'b0000, 1'b0, 4'b0000, -1};

        bus.din_user    = '0;
        bus.vld_user    = '0;
        bus.resend      = 1'b0;
        bus.credit_vld  = 1'b0;
        bus.credit_port = '0;
        bus.credit_amt  = '0;
        bus.cfg_wr      = 1'b0;
        bus.cfg_port    = '0;
        bus.cfg_dest    = '0;
`ifdef LEAF_ARB_STATS_EN
        bus.stat_sel    = '0;
`endif
        model_reset();
        last_pkt = '0;
        tick();
        tick();
        chk("reset ack", 64'(bus.ack_user), 64'd0);
        chk("reset dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        chk("reset err", 64'(bus.credit_err), 64'd0);
        reset_bft_n = 1'b1;
        tick();

        // Single packet from port 0 with a configured destination.
        bus.cfg_wr = 1'b1; bus.cfg_port = 4'd0; bus.cfg_dest = {5'd3, 4'd2};
        tick();
        bus.cfg_wr = 1'b0;
        bus.vld_user[0] = 1'b1;
        bus.din_user[31:0] = 32'hDEADBEEF;
        tick();
        chk("t1 ack", 64'(bus.ack_user), 64'b0001);
        chk("t1 dout", 64'(bus.dout_leaf_interface2bft), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
        bus.vld_user[0] = 1'b0;
        tick();
        chk("t1 ack pulse", 64'(bus.ack_user), 64'd0);
        chk("t1 idle", 64'(bus.dout_leaf_interface2bft[PACKET_BITS-1]), 64'd0);

        // Grant in the cfg write cycle still sees the old entry; the next one sees the new one.
        bus.cfg_wr = 1'b1; bus.cfg_port = 4'd1; bus.cfg_dest = {5'd7, 4'd7};
        bus.vld_user[1] = 1'b1;
        bus.din_user[63:32] = 32'h11111111;
        tick();
        chk("cfg old", 64'(bus.dout_leaf_interface2bft), 64'({1'b1, 9'd0, 7'd0, 32'h11111111}));
        bus.cfg_wr = 1'b0;
        bus.vld_user[1] = 1'b0;
        tick();
        bus.vld_user[1] = 1'b1;
        tick();
        chk("cfg new", 64'(bus.dout_leaf_interface2bft), 64'({1'b1, 5'd7, 4'd7, 7'd1, 32'h11111111}));
        bus.vld_user[1] = 1'b0;
        tick();
        seq_m[0] = 7'd1; credit_m[0] = INIT_CRED - 1;
        seq_m[1] = 7'd2; credit_m[1] = INIT_CRED - 2;

        for (int p = 0; p < NP; p++) begin
            dest_m[p] = {5'(p + 4), 4'(15 - p)};
            din_m[p]  = 32'hC0DE0000 + 32'(p * 32'h111);
            bus.cfg_wr = 1'b1; bus.cfg_port = 4'(p); bus.cfg_dest = dest_m[p];
            tick();
        end
        bus.cfg_wr = 1'b0;
        drive_din();

        // Round-robin order, resend freeze/resume, two-port fairness, sole-port masking.
        for (int r = 0; r < NV; r++) begin
            bus.vld_user = tbl[r].vld;
            bus.resend   = tbl[r].rs;
            if (tbl[r].port >= 0) sb.push_back(mk(tbl[r].port));
            tick();
            chk($sformatf("ack r%0d", r), 64'(bus.ack_user), 64'(tbl[r].ack));
            if (tbl[r].port >= 0)
                pop_chk($sformatf("pkt r%0d", r));
            else if (tbl[r].port == -1)
                chk($sformatf("idle r%0d", r), 64'(bus.dout_leaf_interface2bft[PACKET_BITS-1]), 64'd0);
            else
                chk($sformatf("held r%0d", r), 64'(bus.dout_leaf_interface2bft), 64'(last_pkt));
        end
        bus.vld_user = '0;
        bus.resend   = 1'b0;
        tick();

        // Credit exhaustion on port 1, then exactly one more packet per returned credit.
        run_port(1, credit_m[1], 2 * credit_m[1] + 8, 1'b0, 0);
        run_port(1, 1, 10, 1'b0, 1);

        // Fill port 3 to 255, then overflow: saturates and latches the error.
        bus.credit_vld = 1'b1; bus.credit_port = 4'd3; bus.credit_amt = CB'(255 - credit_m[3]);
        credit_m[3] = 255;
        tick();
        bus.credit_vld = 1'b0;
        chk("err at 255", 64'(bus.credit_err), 64'd0);
        bus.credit_vld = 1'b1; bus.credit_port = 4'd3; bus.credit_amt = 8'd5;
        tick();
        bus.credit_vld = 1'b0;
        chk("err overflow", 64'(bus.credit_err), 64'd1);
        run_port(3, 255, 2 * 255 + 8, 1'b0, 0);
        chk("err sticky", 64'(bus.credit_err), 64'd1);

        // Asynchronous reset while an ack is in flight.
        bus.vld_user[0] = 1'b1;
        sb.push_back(mk(0));
        tick();
        chk("pre-rst ack", 64'(bus.ack_user), 64'b0001);
        pop_chk("pre-rst pkt");
        #2 reset_bft_n = 1'b0;
        #1;
        chk("async ack", 64'(bus.ack_user), 64'd0);
        chk("async dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        chk("async err", 64'(bus.credit_err), 64'd0);
        bus.vld_user = '0;
        model_reset();
        tick();
        tick();
        reset_bft_n = 1'b1;
        tick();

        // Credit return to a nonexistent port.
        bus.credit_vld = 1'b1; bus.credit_port = 4'd9; bus.credit_amt = 8'd1;
        tick();
        bus.credit_vld = 1'b0;
        chk("err bad port", 64'(bus.credit_err), 64'd1);
        tick();
        chk("err bad sticky", 64'(bus.credit_err), 64'd1);

        // 130 packets from port 2: address wraps 127 -> 0.
        run_port(2, 130, 2 * 130 + 8, 1'b1, 100);
`ifdef LEAF_ARB_STATS_EN
        bus.stat_sel = 4'd2;
        #1;
        chk("stat p2", 64'(bus.stat_cnt), 64'd130);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
